// File: rtl/mux_2to1_lat.sv
// rtl/mux_2to1_lat.sv - clocked 2:1 select feeding min/typ/max latency pipelines
// One combinational select result fans out to three independent shift pipelines.

module mux_lat_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Reset discards everything in flight rather than letting it drain out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

module mux_2to1_lat #(
  parameter int WIDTH   = 1,
  parameter int MIN_LAT = 1,
  parameter int TYP_LAT = 2,
  parameter int MAX_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] minO,
  output logic [WIDTH-1:0] maxO,
  output logic [WIDTH-1:0] typO,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             s
);

  if (MIN_LAT < 1 || MIN_LAT > TYP_LAT || TYP_LAT > MAX_LAT || MAX_LAT > 16) begin : g_bad_lat
    $error("mux_2to1_lat: illegal latency set MIN=%0d TYP=%0d MAX=%0d", MIN_LAT, TYP_LAT, MAX_LAT);
  end

  logic [WIDTH-1:0] sel_d;

  assign sel_d = s ? in2 : in1;

  mux_lat_pipe #(.WIDTH(WIDTH), .DEPTH(MIN_LAT)) u_min_pipe (
    .clk    (clk),
    .rst    (rst),
    .din_i  (sel_d),
    .dout_o (minO)
  );

  mux_lat_pipe #(.WIDTH(WIDTH), .DEPTH(TYP_LAT)) u_typ_pipe (
    .clk    (clk),
    .rst    (rst),
    .din_i  (sel_d),
    .dout_o (typO)
  );

  mux_lat_pipe #(.WIDTH(WIDTH), .DEPTH(MAX_LAT)) u_max_pipe (
    .clk    (clk),
    .rst    (rst),
    .din_i  (sel_d),
    .dout_o (maxO)
  );

endmodule

// File: tb/tb_mux_2to1_lat.sv
// tb/tb_mux_2to1_lat.sv - scoreboard bench for mux_2to1_lat (default and WIDTH=4 all-latency-1 variants)

module tb_mux_2to1_lat;

  localparam int MIN_L = 1;
  localparam int TYP_L = 2;
  localparam int MAX_L = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] in1, in2;
  logic       s;
  logic [0:0] min_o, typ_o, max_o;

  logic [3:0] w_in1, w_in2;
  logic       w_s;
  logic [3:0] w_min, w_typ, w_max;

  int checks = 0;
  int errors = 0;

  logic [0:0] q_min [$];
  logic [0:0] q_typ [$];
  logic [0:0] q_max [$];
  logic [3:0] q_w   [$];

  always #5 clk = ~clk;

  mux_2to1_lat #(.WIDTH(1), .MIN_LAT(MIN_L), .TYP_LAT(TYP_L), .MAX_LAT(MAX_L)) dut (
    .clk  (clk),
    .rst  (rst),
    .minO (min_o),
    .maxO (max_o),
    .typO (typ_o),
    .in1  (in1),
    .in2  (in2),
    .s    (s)
  );

  mux_2to1_lat #(.WIDTH(4), .MIN_LAT(1), .TYP_LAT(1), .MAX_LAT(1)) dut_w4 (
    .clk  (clk),
    .rst  (rst),
    .minO (w_min),
    .maxO (w_max),
    .typO (w_typ),
    .in1  (w_in1),
    .in2  (w_in2),
    .s    (w_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, advance the scoreboard at the edge, then compare just after it.
  task automatic step(input logic r, input logic a, input logic b, input logic sel);
    logic [0:0] e_min, e_typ, e_max, sv;
    logic [3:0] e_w;
    rst = r; in1 = a; in2 = b; s = sel;
    @(posedge clk);
    sv = r ? 1'b0 : (sel ? b : a);
    if (r) begin
      q_min.delete(); repeat (MIN_L - 1) q_min.push_back(1'b0);
      q_typ.delete(); repeat (TYP_L - 1) q_typ.push_back(1'b0);
      q_max.delete(); repeat (MAX_L - 1) q_max.push_back(1'b0);
      q_w.delete();
    end
    q_min.push_back(sv);
    q_typ.push_back(sv);
    q_max.push_back(sv);
    q_w.push_back(r ? 4'h0 : (w_s ? w_in2 : w_in1));
    e_min = q_min.pop_front();
    e_typ = q_typ.pop_front();
    e_max = q_max.pop_front();
    e_w   = q_w.pop_front();
    #1;
    check_eq("minO", 32'(min_o), 32'(e_min));
    check_eq("typO", 32'(typ_o), 32'(e_typ));
    check_eq("maxO", 32'(max_o), 32'(e_max));
    check_eq("w4_minO", 32'(w_min), 32'(e_w));
    check_eq("w4_typO", 32'(w_typ), 32'(e_w));
    check_eq("w4_maxO", 32'(w_max), 32'(e_w));
    // Between-edge input changes must not leak into the next sample.
    in1 = ~a; in2 = ~b; s = ~sel;
  endtask

  initial begin
    logic [2:0] tt;
    rst = 1'b1; in1 = 1'b0; in2 = 1'b0; s = 1'b0;
    w_in1 = 4'hA; w_in2 = 4'h5; w_s = 1'b1;

    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    step(0, 1, 1, 1);
    check_eq("w4_after_release", 32'(w_min), 32'h5);

    for (int i = 0; i < 8; i++) begin
      tt = 3'(i);
      step(0, tt[2], tt[1], tt[0]);
    end
    repeat (3) step(0, 0, 0, 0);

    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);

    for (int i = 0; i < 8; i++) step(0, 0, 1, 1'(i));

    repeat (5) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (5) step(0, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      w_in1 = 4'($urandom); w_in2 = 4'($urandom); w_s = 1'($urandom);
      step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
